fx_param_ctrl: RTL and testbench

Parameter sequencer for one FX slot (distortion: drive/tone/mix). Accepts host register writes into shadow registers, commits them atomically on request, and slews the live parameters toward the committed targets one step per audio sample to avoid zipper noise. Sits between the control-register bus and the FX datapath. Forwards a realigned sample strobe so the FX block always samples settled parameters.

---
 rtl/fx_param_ctrl.sv | 147 ++++++++++++++
 tb/tb_fx_param_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fx_param_ctrl.sv
// fx_param_ctrl
// Parameter sequencer for one distortion FX slot (drive/tone/mix).
// The host writes shadow registers. A commit copies all three shadows into
// the targets at once, and the live outputs then slew toward the targets by
// at most STEP per audio sample so the FX path never hears a zipper step.
module fx_param_ctrl #(
  parameter int PARAM_W   = 8,
  parameter int STEP      = 4,
  parameter int DRIVE_RST = 0,
  parameter int TONE_RST  = 128,
  parameter int MIX_RST   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [1:0]         wr_addr,
  input  logic [PARAM_W-1:0] wr_data,
  input  logic               sample_en,
  output logic [PARAM_W-1:0] fx_drive,
  output logic [PARAM_W-1:0] fx_tone,
  output logic [PARAM_W-1:0] fx_mix,
  output logic               fx_sample_en,
  output logic               busy
);

  localparam logic [PARAM_W-1:0] STEP_V      = PARAM_W'(STEP);
  localparam logic [PARAM_W-1:0] DRIVE_RST_V = PARAM_W'(DRIVE_RST);
  localparam logic [PARAM_W-1:0] TONE_RST_V  = PARAM_W'(TONE_RST);
  localparam logic [PARAM_W-1:0] MIX_RST_V   = PARAM_W'(MIX_RST);

  localparam logic [1:0] ADDR_DRIVE = 2'd0;
  localparam logic [1:0] ADDR_TONE  = 2'd1;
  localparam logic [1:0] ADDR_MIX   = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RAMP = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [PARAM_W-1:0] shadow_drive, shadow_tone, shadow_mix;
  logic [PARAM_W-1:0] target_drive, target_tone, target_mix;
  logic [PARAM_W-1:0] live_drive, live_tone, live_mix;
  logic [PARAM_W-1:0] next_drive, next_tone, next_mix;
  logic               wr_fire;
  logic               commit;
  logic               step_en;
  logic               settled;

  // Move one live value toward its target by at most STEP, landing exactly
  // on the target when it is within reach so it can never overshoot or wrap.
  function automatic logic [PARAM_W-1:0] step_toward(
    input logic [PARAM_W-1:0] cur,
    input logic [PARAM_W-1:0] tgt
  );
    logic [PARAM_W-1:0] res;
    res = tgt;
    if (tgt > cur) begin
      if ((tgt - cur) > STEP_V) res = cur + STEP_V;
    end else if (cur > tgt) begin
      if ((cur - tgt) > STEP_V) res = cur - STEP_V;
    end
    return res;
  endfunction

  // Only a control write is ever stalled, and only while a ramp is running.
  assign wr_ready = (state == S_IDLE) || (wr_addr != ADDR_CTRL);
  assign wr_fire  = wr_valid && wr_ready;
  assign commit   = wr_fire && (wr_addr == ADDR_CTRL) && wr_data[0];

  // A commit only loads targets, so stepping is driven purely by RAMP state.
  assign step_en    = (state == S_RAMP) && sample_en;
  assign next_drive = step_toward(live_drive, target_drive);
  assign next_tone  = step_toward(live_tone,  target_tone);
  assign next_mix   = step_toward(live_mix,   target_mix);
  assign settled    = (next_drive == target_drive) &&
                      (next_tone  == target_tone)  &&
                      (next_mix   == target_mix);

  // Next-state logic for the IDLE/RAMP sequencer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (commit) state_next = S_RAMP;
      S_RAMP:  if (step_en && settled) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Shadow registers take host writes in either state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_drive <= DRIVE_RST_V;
      shadow_tone  <= TONE_RST_V;
      shadow_mix   <= MIX_RST_V;
    end else if (wr_fire) begin
      if (wr_addr == ADDR_DRIVE) shadow_drive <= wr_data;
      if (wr_addr == ADDR_TONE)  shadow_tone  <= wr_data;
      if (wr_addr == ADDR_MIX)   shadow_mix   <= wr_data;
    end
  end

  // Targets snapshot all three shadows together so a commit is atomic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_drive <= DRIVE_RST_V;
      target_tone  <= TONE_RST_V;
      target_mix   <= MIX_RST_V;
    end else if (commit) begin
      target_drive <= shadow_drive;
      target_tone  <= shadow_tone;
      target_mix   <= shadow_mix;
    end
  end

  // Live registers slew one step per audio sample while ramping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_drive <= DRIVE_RST_V;
      live_tone  <= TONE_RST_V;
      live_mix   <= MIX_RST_V;
    end else if (step_en) begin
      live_drive <= next_drive;
      live_tone  <= next_tone;
      live_mix   <= next_mix;
    end
  end

  // Strobe to the FX block trails sample_en so it lines up with new values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fx_sample_en <= 1'b0;
    else          fx_sample_en <= sample_en;
  end

  assign fx_drive = live_drive;
  assign fx_tone  = live_tone;
  assign fx_mix   = live_mix;
  assign busy     = (state == S_RAMP);

endmodule

// File: tb/tb_fx_param_ctrl.sv
// Testbench for fx_param_ctrl: a table of directed write/sample vectors with
// hand-computed expectations, followed by hand-written multi-cycle sequences
// for held-off commits, same-cycle commit/sample, async reset and STEP=255.
module tb_fx_param_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic       wr_ready, wr_ready2;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       sample_en;
  logic [7:0] fx_drive, fx_tone, fx_mix;
  logic [7:0] fx_drive2, fx_tone2, fx_mix2;
  logic       fx_sample_en, fx_sample_en2;
  logic       busy, busy2;

  int vec_count;
  int miss_count;

  fx_param_ctrl #(.PARAM_W(8), .STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .sample_en(sample_en),
    .fx_drive(fx_drive), .fx_tone(fx_tone), .fx_mix(fx_mix),
    .fx_sample_en(fx_sample_en), .busy(busy)
  );

  fx_param_ctrl #(.PARAM_W(8), .STEP(255)) dut_big (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_addr(wr_addr), .wr_data(wr_data), .sample_en(sample_en),
    .fx_drive(fx_drive2), .fx_tone(fx_tone2), .fx_mix(fx_mix2),
    .fx_sample_en(fx_sample_en2), .busy(busy2)
  );

  typedef struct {
    string      name;
    logic       is_sample;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] e_drive;
    logic [7:0] e_tone;
    logic [7:0] e_mix;
    logic       e_busy;
  } vec_t;

  vec_t vecs[12];

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string name, input int d, input int t, input int m,
                          input int b, input int se);
    checkOutput({name, ".drive"}, fx_drive, d);
    checkOutput({name, ".tone"},  fx_tone,  t);
    checkOutput({name, ".mix"},   fx_mix,   m);
    checkOutput({name, ".busy"},  busy,     b);
    checkOutput({name, ".fx_sample_en"}, fx_sample_en, se);
  endtask

  // One host write transfer; the write is expected to be accepted.
  task automatic applyStimulus(input string name, input logic [1:0] addr, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    #1;
    checkOutput({name, ".wr_ready"}, wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  // One-cycle audio sample strobe.
  task automatic pulseSample();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int exp_drive;
    int steps;

    vec_count  = 0;
    miss_count = 0;
    reset_n    = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = 2'd0;
    wr_data    = 8'd0;
    sample_en  = 1'b0;

    vecs[0]  = '{"wr_drive10",   1'b0, 2'd0, 8'd10,  8'd0,  8'd128, 8'd0, 1'b0};
    vecs[1]  = '{"commit1",      1'b0, 2'd3, 8'd1,   8'd0,  8'd128, 8'd0, 1'b1};
    vecs[2]  = '{"up_s1",        1'b1, 2'd0, 8'd0,   8'd4,  8'd128, 8'd0, 1'b1};
    vecs[3]  = '{"up_s2",        1'b1, 2'd0, 8'd0,   8'd8,  8'd128, 8'd0, 1'b1};
    vecs[4]  = '{"up_s3",        1'b1, 2'd0, 8'd0,   8'd10, 8'd128, 8'd0, 1'b0};
    vecs[5]  = '{"wr_tone120",   1'b0, 2'd1, 8'd120, 8'd10, 8'd128, 8'd0, 1'b0};
    vecs[6]  = '{"commit2",      1'b0, 2'd3, 8'd1,   8'd10, 8'd128, 8'd0, 1'b1};
    vecs[7]  = '{"down_s1",      1'b1, 2'd0, 8'd0,   8'd10, 8'd124, 8'd0, 1'b1};
    vecs[8]  = '{"down_s2",      1'b1, 2'd0, 8'd0,   8'd10, 8'd120, 8'd0, 1'b0};
    vecs[9]  = '{"ctrl_nop",     1'b0, 2'd3, 8'd0,   8'd10, 8'd120, 8'd0, 1'b0};
    vecs[10] = '{"commit_same",  1'b0, 2'd3, 8'd1,   8'd10, 8'd120, 8'd0, 1'b1};
    vecs[11] = '{"same_s1",      1'b1, 2'd0, 8'd0,   8'd10, 8'd120, 8'd0, 1'b0};

    // Reset values, checked while reset is still held.
    tick();
    checkAll("reset", 0, 128, 0, 0, 0);
    checkOutput("reset.wr_ready", wr_ready, 1);
    reset_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_sample) pulseSample();
      else applyStimulus(vecs[i].name, vecs[i].addr, vecs[i].data);
      checkAll(vecs[i].name, vecs[i].e_drive, vecs[i].e_tone, vecs[i].e_mix,
               vecs[i].e_busy, vecs[i].is_sample ? 1 : 0);
    end
    tick();
    checkOutput("strobe_trail", fx_sample_en, 0);

    // Shadow write during ramp does not disturb it; commit is held off.
    applyStimulus("wr_drive30", 2'd0, 8'd30);
    applyStimulus("commit3", 2'd3, 8'd1);
    pulseSample();
    checkAll("hold_s1", 14, 120, 0, 1, 1);
    applyStimulus("wr_drive200_ramp", 2'd0, 8'd200);
    wr_valid = 1'b1;
    wr_addr  = 2'd3;
    wr_data  = 8'd1;
    #1;
    checkOutput("held_ready", wr_ready, 0);
    exp_drive = 14;
    for (int i = 0; i < 4; i++) begin
      pulseSample();
      exp_drive = (exp_drive + 4 > 30) ? 30 : exp_drive + 4;
      checkOutput("hold_ramp.drive", fx_drive, exp_drive);
      checkOutput("hold_ramp.wr_ready", wr_ready, (i == 3) ? 1 : 0);
    end
    checkOutput("hold_done.busy", busy, 0);
    tick();
    wr_valid = 1'b0;
    checkOutput("held_commit.busy", busy, 1);
    checkOutput("held_commit.drive", fx_drive, 30);

    // Ramp 30 -> 200 takes ceil(170/4) = 43 samples; bounded loop.
    exp_drive = 30;
    steps = 0;
    while (busy && steps < 60) begin
      pulseSample();
      steps++;
      exp_drive = (exp_drive + 4 > 200) ? 200 : exp_drive + 4;
      checkOutput("ramp200.drive", fx_drive, exp_drive);
    end
    checkOutput("ramp200.steps", steps, 43);
    checkOutput("ramp200.final", fx_drive, 200);

    // Commit on a sample_en cycle: targets load, no step that sample.
    applyStimulus("wr_tone128", 2'd1, 8'd128);
    wr_valid  = 1'b1;
    wr_addr   = 2'd3;
    wr_data   = 8'd1;
    sample_en = 1'b1;
    tick();
    wr_valid  = 1'b0;
    sample_en = 1'b0;
    checkAll("commit_on_sample", 200, 120, 0, 1, 1);
    pulseSample();
    checkAll("cos_s1", 200, 124, 0, 1, 1);
    pulseSample();
    checkAll("cos_s2", 200, 128, 0, 0, 1);

    // Asynchronous reset in the middle of a ramp.
    applyStimulus("wr_drive0", 2'd0, 8'd0);
    applyStimulus("commit4", 2'd3, 8'd1);
    pulseSample();
    checkAll("pre_reset", 196, 128, 0, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkAll("async_reset", 0, 128, 0, 0, 0);
    checkOutput("async_reset.wr_ready", wr_ready, 1);
    #1;
    reset_n = 1'b1;
    tick();

    // STEP=255 instance jumps mix 0 -> 255 in one sample.
    doReset();
    applyStimulus("wr_mix255", 2'd2, 8'd255);
    applyStimulus("commit5", 2'd3, 8'd1);
    checkOutput("big.busy_pre", busy2, 1);
    pulseSample();
    checkOutput("big.mix", fx_mix2, 255);
    checkOutput("big.drive", fx_drive2, 0);
    checkOutput("big.tone", fx_tone2, 128);
    checkOutput("big.busy", busy2, 0);
    checkOutput("big.fx_sample_en", fx_sample_en2, 1);
    checkOutput("small.mix", fx_mix, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000 ns");
    miss_count++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $fatal(1, "[TB] timeout");
  end

endmodule
